// File: rtl/mixer_sd_dac.sv
// ---------------------------------------------------------------------------
// mixer_sd_dac
//
// Mixes CH signed audio channels, each with its own volume and mute, into one
// saturated W-bit sample. The mix is computed serially, one channel per clock.
// A first-order sigma-delta modulator turns the latest mixed sample into a
// 1-bit stream for the board audio pins.
//
// Ports
//   clk_i       single clock for all logic
//   res_n_i     asynchronous active-low reset
//   ce_i        sample strobe; starts one mix when the FSM is idle
//   ch_i        CH packed signed samples, channel k at ch_i[k*W +: W]
//   vol_i       CH packed volumes, 0 = silent, 16 = unity, >16 treated as 16
//   mute_i      per-channel mute, 1 zeroes that channel's contribution
//   sample_o    last mixed, saturated sample
//   sample_v_o  one-cycle pulse when sample_o updates
//   clip_o      one-cycle pulse with sample_v_o when the mix saturated
//   overrun_o   one-cycle pulse after a ce_i that arrived mid-mix
//   busy_o      high from the cycle after ce_i until the result is presented
//   dac_o       sigma-delta bitstream
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for ce_i; latched inputs hold the last mix
// ST_ACC   | accumulating channel idx into acc, one channel per cycle
// ST_SAT   | scaling acc by 1/16, clamping, publishing sample_o
// ---------------------------------------------------------------------------
module mixer_sd_dac #(
   parameter int CH   = 2,
   parameter int W    = 16,
   parameter int VOLW = 5
) (
   input  logic                 clk_i,
   input  logic                 res_n_i,
   input  logic                 ce_i,
   input  logic [CH*W-1:0]      ch_i,
   input  logic [CH*VOLW-1:0]   vol_i,
   input  logic [CH-1:0]        mute_i,
   output logic [W-1:0]         sample_o,
   output logic                 sample_v_o,
   output logic                 clip_o,
   output logic                 overrun_o,
   output logic                 busy_o,
   output logic                 dac_o
);

   localparam int IW    = (CH > 1) ? $clog2(CH) : 1;
   localparam int AW    = W + VOLW + $clog2(CH) + 1;
   localparam int PW    = W + VOLW + 1;
   localparam int UNITY = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACC  = 2'd1;
   localparam logic [1:0] ST_SAT  = 2'd2;

   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
   localparam logic [W-1:0]         OUT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]         OUT_MIN = {1'b1, {(W-1){1'b0}}};

   logic [1:0]              state;
   logic [IW-1:0]           idx;
   logic signed [AW-1:0]    acc;
   logic [CH*W-1:0]         ch_lat;
   logic [CH*VOLW-1:0]      vol_lat;
   logic [CH-1:0]           mute_lat;
   logic [W:0]              sd;

   logic signed [W-1:0]     cur_ch;
   logic [VOLW-1:0]         cur_vol;
   logic [VOLW:0]           vol_eff;
   logic signed [PW-1:0]    ch_ext;
   logic signed [PW-1:0]    vol_ext;
   logic signed [PW-1:0]    prod;
   logic signed [AW-1:0]    contrib;
   logic signed [AW-1:0]    acc_nxt;
   logic signed [AW-1:0]    shifted;
   logic                    sat_hi;
   logic                    sat_lo;
   logic [W-1:0]            sat_val;
   logic [W-1:0]            sd_u;

   // ---------------- datapath: one channel per cycle ----------------
   always_comb begin
      cur_ch  = ch_lat[idx*W +: W];
      cur_vol = vol_lat[idx*VOLW +: VOLW];
      vol_eff = {1'b0, cur_vol};
      if (32'(cur_vol) > UNITY) begin
         vol_eff = (VOLW+1)'(UNITY);
      end
      // Both factors widened to the product width before the multiply so
      // the signed product cannot overflow.
      ch_ext  = PW'(cur_ch);
      vol_ext = $signed(PW'({1'b0, vol_eff}));
      prod    = ch_ext * vol_ext;
      contrib = mute_lat[idx] ? '0 : AW'(prod);
      acc_nxt = acc + contrib;
   end

   // ---------------- scale by 1/16 and saturate ----------------
   always_comb begin
      shifted = acc >>> 4;
      sat_hi  = (shifted > SAT_MAX);
      sat_lo  = (shifted < SAT_MIN);
      sat_val = shifted[W-1:0];
      if (sat_hi) begin
         sat_val = OUT_MAX;
      end else if (sat_lo) begin
         sat_val = OUT_MIN;
      end
   end

   // ---------------- control FSM ----------------
   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         state      <= ST_IDLE;
         idx        <= '0;
         acc        <= '0;
         ch_lat     <= '0;
         vol_lat    <= '0;
         mute_lat   <= '0;
         sample_o   <= '0;
         sample_v_o <= 1'b0;
         clip_o     <= 1'b0;
         overrun_o  <= 1'b0;
      end else begin
         sample_v_o <= 1'b0;
         clip_o     <= 1'b0;
         overrun_o  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ce_i) begin
                  ch_lat   <= ch_i;
                  vol_lat  <= vol_i;
                  mute_lat <= mute_i;
                  acc      <= '0;
                  idx      <= '0;
                  state    <= ST_ACC;
               end
            end
            ST_ACC: begin
               overrun_o <= ce_i;
               acc       <= acc_nxt;
               if (idx == IW'(CH-1)) begin
                  state <= ST_SAT;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            ST_SAT: begin
               overrun_o  <= ce_i;
               sample_o   <= sat_val;
               sample_v_o <= 1'b1;
               clip_o     <= sat_hi | sat_lo;
               state      <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // The FSM is already idle while the result pulse is visible; busy_o
   // stays high through that cycle so it brackets the whole mix.
   assign busy_o = (state != ST_IDLE) | sample_v_o;

   // ---------------- first-order sigma-delta ----------------
   // Offset-binary input; the carry out of the W-bit accumulator is the
   // output bit, so its density is sd_u / 2^W.
   assign sd_u = {~sample_o[W-1], sample_o[W-2:0]};

   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         sd    <= '0;
         dac_o <= 1'b0;
      end else begin
         sd    <= {1'b0, sd[W-1:0]} + {1'b0, sd_u};
         dac_o <= sd[W];
      end
   end

endmodule

// File: tb/tb_mixer_sd_dac.sv
module tb_mixer_sd_dac;

   localparam int CH   = 2;
   localparam int W    = 16;
   localparam int VOLW = 5;

   logic                clk = 1'b0;
   logic                res_n = 1'b0;
   logic                ce = 1'b0;
   logic [CH*W-1:0]     ch = '0;
   logic [CH*VOLW-1:0]  vol = '0;
   logic [CH-1:0]       mute = '0;
   logic [W-1:0]        sample_o;
   logic                sample_v_o;
   logic                clip_o;
   logic                overrun_o;
   logic                busy_o;
   logic                dac_o;

   mixer_sd_dac #(.CH(CH), .W(W), .VOLW(VOLW)) dut (
      .clk_i      (clk),
      .res_n_i    (res_n),
      .ce_i       (ce),
      .ch_i       (ch),
      .vol_i      (vol),
      .mute_i     (mute),
      .sample_o   (sample_o),
      .sample_v_o (sample_v_o),
      .clip_o     (clip_o),
      .overrun_o  (overrun_o),
      .busy_o     (busy_o),
      .dac_o      (dac_o)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] s;
      logic        clip;
   } exp_t;

   typedef struct {
      logic [15:0] c0;
      logic [15:0] c1;
      logic [4:0]  v0;
      logic [4:0]  v1;
      logic [1:0]  m;
      logic [15:0] s;
      logic        clip;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [15:0] c0, input logic [15:0] c1,
                         input logic [4:0] v0, input logic [4:0] v1, input logic [1:0] m);
      ch   = {c1, c0};
      vol  = {v1, v0};
      mute = m;
   endtask

   task automatic scramble_in();
      ch   = {16'($urandom), 16'($urandom)};
      vol  = 10'($urandom);
      mute = 2'($urandom);
   endtask

   function automatic void model(input logic [15:0] c0, input logic [15:0] c1,
                                 input logic [4:0] v0, input logic [4:0] v1, input logic [1:0] m,
                                 output logic [15:0] s, output logic clip);
      longint acc;
      longint sh;
      int     ve0;
      int     ve1;
      ve0 = (int'(v0) > 16) ? 16 : int'(v0);
      ve1 = (int'(v1) > 16) ? 16 : int'(v1);
      acc = 0;
      if (!m[0]) acc += longint'($signed(c0)) * ve0;
      if (!m[1]) acc += longint'($signed(c1)) * ve1;
      sh = acc >>> 4;
      if (sh > 32767) begin
         s = 16'h7FFF; clip = 1'b1;
      end else if (sh < -32768) begin
         s = 16'h8000; clip = 1'b1;
      end else begin
         s = sh[15:0]; clip = 1'b0;
      end
   endfunction

   // Scoreboard: every result pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (res_n) begin
         if (sample_v_o) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_sample actual=0x%0h required=none", sample_o);
            end else begin
               e = sb_q.pop_front();
               check("sample_o", 32'(sample_o), 32'(e.s));
               check("clip_o", 32'(clip_o), 32'(e.clip));
            end
         end else if (clip_o) begin
            check("clip_without_valid", 32'(clip_o), 32'd0);
         end
      end
   end

   int ones;
   int seen;
   logic [15:0] es;
   logic        ec;
   logic [15:0] rc0, rc1;
   logic [4:0]  rv0, rv1;
   logic [1:0]  rm;

   initial begin
      vecs[0] = '{16'h1234, 16'h5555, 5'd16, 5'd16, 2'b10, 16'h1234, 1'b0};
      vecs[1] = '{16'h7000, 16'h7000, 5'd16, 5'd16, 2'b00, 16'h7FFF, 1'b1};
      vecs[2] = '{16'h9000, 16'h9000, 5'd16, 5'd16, 2'b00, 16'h8000, 1'b1};
      vecs[3] = '{16'h4000, 16'h0000, 5'd8,  5'd16, 2'b00, 16'h2000, 1'b0};
      vecs[4] = '{16'h4000, 16'h0000, 5'd31, 5'd16, 2'b00, 16'h4000, 1'b0};
      vecs[5] = '{16'h4000, 16'h1000, 5'd0,  5'd16, 2'b00, 16'h1000, 1'b0};
      vecs[6] = '{16'hFFFF, 16'h0000, 5'd1,  5'd16, 2'b00, 16'hFFFF, 1'b0};
      vecs[7] = '{16'h7FFF, 16'h0001, 5'd16, 5'd16, 2'b00, 16'h7FFF, 1'b1};
      vecs[8] = '{16'h8000, 16'h8000, 5'd16, 5'd16, 2'b11, 16'h0000, 1'b0};
      vecs[9] = '{16'h8000, 16'h7FFF, 5'd16, 5'd16, 2'b00, 16'hFFFF, 1'b0};

      // reset state
      #1;
      check("rst_sample_o", 32'(sample_o), 32'd0);
      check("rst_sample_v", 32'(sample_v_o), 32'd0);
      check("rst_clip", 32'(clip_o), 32'd0);
      check("rst_overrun", 32'(overrun_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_dac", 32'(dac_o), 32'd0);
      repeat (2) tick();
      res_n = 1'b1;

      // sample_o = 0 is mid-scale: exactly half density over an even window
      repeat (4) tick();
      ones = 0;
      repeat (8192) begin
         @(negedge clk);
         ones += int'(dac_o);
      end
      check("dac_ones_zero", 32'(ones), 32'd4096);
      tick();

      // table vectors with latency and input-latching checks
      for (int i = 0; i < 10; i++) begin
         set_in(vecs[i].c0, vecs[i].c1, vecs[i].v0, vecs[i].v1, vecs[i].m);
         sb_q.push_back('{vecs[i].s, vecs[i].clip});
         ce = 1'b1;
         tick();
         ce = 1'b0;
         scramble_in();
         check("busy_t1", 32'(busy_o), 32'd1);
         repeat (CH) tick();
         check("valid_early", 32'(sample_v_o), 32'd0);
         tick();
         check("valid_latency", 32'(sample_v_o), 32'd1);
         check("busy_at_valid", 32'(busy_o), 32'd1);
         tick();
         check("busy_after", 32'(busy_o), 32'd0);
      end

      // overrun: second ce one cycle after the first
      set_in(16'h1234, 16'h0100, 5'd16, 5'd16, 2'b00);
      sb_q.push_back('{16'h1334, 1'b0});
      ce = 1'b1;
      tick();
      scramble_in();
      check("overrun_t1", 32'(overrun_o), 32'd0);
      tick();
      ce = 1'b0;
      check("overrun_t2", 32'(overrun_o), 32'd1);
      tick();
      check("overrun_t3", 32'(overrun_o), 32'd0);
      check("ovr_valid_t3", 32'(sample_v_o), 32'd0);
      tick();
      check("ovr_valid_t4", 32'(sample_v_o), 32'd1);
      repeat (CH + 3) tick();
      check("ovr_single_result", 32'(sb_q.size()), 32'd0);
      check("ovr_idle", 32'(busy_o), 32'd0);

      // random mixes against the model
      for (int i = 0; i < 16; i++) begin
         rc0 = 16'($urandom);
         rc1 = 16'($urandom);
         rv0 = 5'($urandom_range(0, 31));
         rv1 = 5'($urandom_range(0, 31));
         rm  = 2'($urandom_range(0, 3));
         if (i < 4) rm = 2'b00;
         model(rc0, rc1, rv0, rv1, rm, es, ec);
         set_in(rc0, rc1, rv0, rv1, rm);
         sb_q.push_back('{es, ec});
         ce = 1'b1;
         tick();
         ce = 1'b0;
         repeat (CH + 2) tick();
      end

      // full-scale positive: 65535 ones in a 65536-cycle window
      set_in(16'h7000, 16'h7000, 5'd16, 5'd16, 2'b00);
      sb_q.push_back('{16'h7FFF, 1'b1});
      ce = 1'b1;
      tick();
      ce = 1'b0;
      repeat (CH + 6) tick();
      ones = 0;
      repeat (65536) begin
         @(negedge clk);
         ones += int'(dac_o);
      end
      check("dac_ones_full", 32'(ones), 32'd65535);
      tick();

      // reset during a mix aborts it
      set_in(16'h2000, 16'h1000, 5'd16, 5'd16, 2'b00);
      ce = 1'b1;
      tick();
      ce = 1'b0;
      tick();
      #2;
      res_n = 1'b0;
      #1;
      check("abort_sample_o", 32'(sample_o), 32'd0);
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_dac", 32'(dac_o), 32'd0);
      check("abort_valid", 32'(sample_v_o), 32'd0);
      repeat (3) tick();
      res_n = 1'b1;
      seen = 0;
      repeat (CH + 4) begin
         tick();
         seen += int'(sample_v_o);
      end
      check("abort_no_valid", 32'(seen), 32'd0);

      // fresh mix after release
      set_in(16'h2000, 16'h1000, 5'd16, 5'd8, 2'b00);
      sb_q.push_back('{16'h2800, 1'b0});
      ce = 1'b1;
      tick();
      ce = 1'b0;
      repeat (CH) tick();
      check("post_rst_early", 32'(sample_v_o), 32'd0);
      tick();
      check("post_rst_valid", 32'(sample_v_o), 32'd1);

      for (int k = 0; k < 20 && sb_q.size() != 0; k++) tick();
      check("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
